// File: rtl/muon_decay_sequencer.sv
// muon_decay_sequencer
//   Drives one countdown timer that bounds the decay window of the muon
//   lifetime measurement. A rising hit edge while armed opens the window and
//   starts the timer. The next rising edge at least MIN_GAP cycles later is
//   taken as the decay: its lifetime goes out over a valid/ready port and the
//   timer is cancelled. Timer expiry counts as a timeout. Every decay or
//   timeout is followed by a DEAD_CYCLES holdoff.
//
// Ports
//   clk            system clock
//   rst            synchronous reset, active high
//   enable         run enable (level)
//   hit            discriminator output, synchronous to clk
//   tmr_start      one-cycle pulse, starts the countdown timer
//   tmr_stop       one-cycle pulse, cancels the countdown timer
//   tmr_done       timer expiry, only looked at in WINDOW
//   result_data    measured lifetime in clk cycles
//   result_valid   result handshake valid
//   result_ready   result handshake ready
//   decay_count    accepted decays, saturating
//   timeout_count  timeouts, saturating
//   busy           high in WINDOW, REPORT and DEAD
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | run disabled, waiting for enable
// ARMED  | enabled, waiting for the muon-arrival edge
// WINDOW | timer running, counting cycles until decay edge or expiry
// REPORT | holding the lifetime result until it is accepted
// DEAD   | holdoff after a decay or timeout, all edges ignored

module muon_decay_sequencer #(
  parameter int CNT_W       = 32,
  parameter int MIN_GAP     = 3,
  parameter int DEAD_CYCLES = 8,
  parameter int STAT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              hit,
  output logic              tmr_start,
  output logic              tmr_stop,
  input  logic              tmr_done,
  output logic [CNT_W-1:0]  result_data,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [STAT_W-1:0] decay_count,
  output logic [STAT_W-1:0] timeout_count,
  output logic              busy
);

  localparam int DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  MIN_GAP_C = CNT_W'(MIN_GAP);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [STAT_W-1:0] STAT_MAX  = '1;
  // Holdoff is a down-counter; loading N-1 and leaving on zero gives N cycles.
  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_WINDOW,
    S_REPORT,
    S_DEAD
  } state_t;

  state_t             state, state_nxt;
  logic               hit_q;
  logic               hit_rise;
  logic [CNT_W-1:0]   elapsed, elapsed_nxt;
  logic [DEAD_W-1:0]  dead_cnt, dead_cnt_nxt;
  logic [CNT_W-1:0]   result_data_nxt;
  logic               result_valid_nxt;
  logic               tmr_start_nxt, tmr_stop_nxt;
  logic [STAT_W-1:0]  decay_count_nxt, timeout_count_nxt;
  logic               busy_nxt;

  assign hit_rise = hit & ~hit_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      hit_q         <= 1'b0;
      elapsed       <= '0;
      dead_cnt      <= '0;
      result_data   <= '0;
      result_valid  <= 1'b0;
      tmr_start     <= 1'b0;
      tmr_stop      <= 1'b0;
      decay_count   <= '0;
      timeout_count <= '0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nxt;
      // Tracked in every state so a hit held across DEAD->ARMED is not an edge.
      hit_q         <= hit;
      elapsed       <= elapsed_nxt;
      dead_cnt      <= dead_cnt_nxt;
      result_data   <= result_data_nxt;
      result_valid  <= result_valid_nxt;
      tmr_start     <= tmr_start_nxt;
      tmr_stop      <= tmr_stop_nxt;
      decay_count   <= decay_count_nxt;
      timeout_count <= timeout_count_nxt;
      busy          <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    elapsed_nxt       = elapsed;
    dead_cnt_nxt      = dead_cnt;
    result_data_nxt   = result_data;
    result_valid_nxt  = result_valid;
    tmr_start_nxt     = 1'b0;
    tmr_stop_nxt      = 1'b0;
    decay_count_nxt   = decay_count;
    timeout_count_nxt = timeout_count;

    case (state)
      S_IDLE: begin
        if (enable) state_nxt = S_ARMED;
      end

      S_ARMED: begin
        if (!enable) begin
          state_nxt = S_IDLE;
        end else if (hit_rise) begin
          state_nxt     = S_WINDOW;
          elapsed_nxt   = CNT_W'(1);
          tmr_start_nxt = 1'b1;
        end
      end

      S_WINDOW: begin
        if (elapsed != CNT_MAX) elapsed_nxt = elapsed + CNT_W'(1);
        // Priority: abort, then accepted decay, then timer expiry.
        if (!enable) begin
          state_nxt    = S_IDLE;
          tmr_stop_nxt = 1'b1;
        end else if (hit_rise && (elapsed >= MIN_GAP_C)) begin
          state_nxt        = S_REPORT;
          result_data_nxt  = elapsed;
          result_valid_nxt = 1'b1;
          tmr_stop_nxt     = 1'b1;
          if (decay_count != STAT_MAX) decay_count_nxt = decay_count + STAT_W'(1);
        end else if (tmr_done) begin
          // Timer has already expired on its own, so no cancel pulse.
          state_nxt    = S_DEAD;
          dead_cnt_nxt = DEAD_LOAD;
          if (timeout_count != STAT_MAX) timeout_count_nxt = timeout_count + STAT_W'(1);
        end
      end

      S_REPORT: begin
        if (result_valid && result_ready) begin
          state_nxt        = S_DEAD;
          result_valid_nxt = 1'b0;
          dead_cnt_nxt     = DEAD_LOAD;
        end
      end

      S_DEAD: begin
        if (dead_cnt == '0) begin
          state_nxt = enable ? S_ARMED : S_IDLE;
        end else begin
          dead_cnt_nxt = dead_cnt - DEAD_W'(1);
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    busy_nxt = (state_nxt == S_WINDOW) || (state_nxt == S_REPORT) || (state_nxt == S_DEAD);
  end

endmodule
